// File: rtl/ot_unpack_stream.sv
// ot_unpack_stream
// Oblivious-transfer combine engine. Accepts one job at a time, picks a
// message with the choice bit, reduces message and key modulo N with two
// bit-serial MSB-first reducers, then returns (m - k) mod N or (m + k) mod N
// over a back-pressured output handshake.

module ot_unpack_stream #(
  parameter int W     = 32,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             sel_bit,
  input  logic             op,
  input  logic [W-1:0]     message0,
  input  logic [W-1:0]     message1,
  input  logic [W-1:0]     key,
  input  logic [W-1:0]     modulus,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [W-1:0]     result,
  output logic             out_err,
  output logic [CNT_W-1:0] done_cnt
);

  localparam int CW = $clog2(W);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    REDUCE  = 2'd1,
    COMBINE = 2'd2,
    OUT     = 2'd3
  } stateT;

  stateT r_state;
  stateT w_nextState;

  logic [W-1:0]     r_msg;
  logic [W-1:0]     r_key;
  logic [W-1:0]     r_mod;
  logic             r_op;
  logic [W-1:0]     r_remMsg;
  logic [W-1:0]     r_remKey;
  logic [CW-1:0]    r_cnt;
  logic [W-1:0]     r_result;
  logic             r_err;
  logic [CNT_W-1:0] r_doneCnt;

  logic             w_msgBit;
  logic             w_keyBit;
  logic [W:0]       w_modExt;
  logic [W:0]       w_shiftMsg;
  logic [W:0]       w_shiftKey;
  logic             w_geMsg;
  logic             w_geKey;
  logic [W-1:0]     w_nextRemMsg;
  logic [W-1:0]     w_nextRemKey;
  logic [W:0]       w_sumExt;
  logic             w_sumGe;
  logic [W-1:0]     w_addRes;
  logic [W-1:0]     w_subRes;
  logic [W-1:0]     w_combRes;

  // One reduction step per operand: the W+1-bit doubled remainder decides
  // whether N is subtracted. The true new remainder is always below N, so
  // the subtraction itself can be done modulo 2^W without losing anything.
  assign w_msgBit     = r_msg[r_cnt];
  assign w_keyBit     = r_key[r_cnt];
  assign w_modExt     = {1'b0, r_mod};
  assign w_shiftMsg   = {r_remMsg, w_msgBit};
  assign w_shiftKey   = {r_remKey, w_keyBit};
  assign w_geMsg      = (w_shiftMsg >= w_modExt);
  assign w_geKey      = (w_shiftKey >= w_modExt);
  assign w_nextRemMsg = {r_remMsg[W-2:0], w_msgBit} - (w_geMsg ? r_mod : '0);
  assign w_nextRemKey = {r_remKey[W-2:0], w_keyBit} - (w_geKey ? r_mod : '0);

  // Both remainders are below N here, so the sum needs one extra bit only
  // for the comparison; the final value again fits in W bits.
  assign w_sumExt  = {1'b0, r_remMsg} + {1'b0, r_remKey};
  assign w_sumGe   = (w_sumExt >= w_modExt);
  assign w_addRes  = r_remMsg + r_remKey - (w_sumGe ? r_mod : '0);
  assign w_subRes  = r_remMsg - r_remKey + ((r_remMsg < r_remKey) ? r_mod : '0);
  assign w_combRes = r_op ? w_addRes : w_subRes;

  // State register; reset aborts any job in flight.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_nextState;
    end
  end

  // Next-state decode; a zero modulus skips straight to the output.
  always_comb begin
    w_nextState = r_state;
    case (r_state)
      IDLE: begin
        if (in_valid) begin
          w_nextState = (modulus == '0) ? OUT : REDUCE;
        end
      end
      REDUCE: begin
        if (r_cnt == '0) begin
          w_nextState = COMBINE;
        end
      end
      COMBINE: begin
        w_nextState = OUT;
      end
      OUT: begin
        if (out_ready) begin
          w_nextState = IDLE;
        end
      end
      default: begin
        w_nextState = IDLE;
      end
    endcase
  end

  // Handshake outputs are pure state decodes; result is masked when idle.
  always_comb begin
    in_ready  = (r_state == IDLE) && !rst;
    out_valid = (r_state == OUT);
    result    = out_valid ? r_result : '0;
    out_err   = out_valid && r_err;
    done_cnt  = r_doneCnt;
  end

  // Datapath: capture at accept, shift-reduce, then combine once.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_msg    <= '0;
      r_key    <= '0;
      r_mod    <= '0;
      r_op     <= 1'b0;
      r_remMsg <= '0;
      r_remKey <= '0;
      r_cnt    <= '0;
      r_result <= '0;
      r_err    <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (in_valid) begin
            r_msg    <= sel_bit ? message1 : message0;
            r_key    <= key;
            r_mod    <= modulus;
            r_op     <= op;
            r_remMsg <= '0;
            r_remKey <= '0;
            r_cnt    <= CW'(W - 1);
            if (modulus == '0) begin
              r_result <= '0;
              r_err    <= 1'b1;
            end else begin
              r_err    <= 1'b0;
            end
          end
        end
        REDUCE: begin
          r_remMsg <= w_nextRemMsg;
          r_remKey <= w_nextRemKey;
          if (r_cnt != '0) begin
            r_cnt <= r_cnt - 1'b1;
          end
        end
        COMBINE: begin
          r_result <= w_combRes;
        end
        default: begin
        end
      endcase
    end
  end

  // Completed-job counter steps on each output handshake and wraps.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_doneCnt <= '0;
    end else if ((r_state == OUT) && out_ready) begin
      r_doneCnt <= r_doneCnt + 1'b1;
    end
  end

endmodule

// File: tb/tb_ot_unpack_stream.sv
// Testbench for ot_unpack_stream: a table of jobs driven through the
// handshake with a scoreboard queue, plus hand-written sequences for output
// back-pressure and reset in the middle of a reduction.

module tb_ot_unpack_stream;

  localparam int W     = 32;
  localparam int CNT_W = 16;
  localparam int NVEC  = 13;

  logic             clk;
  logic             rst;
  logic             in_valid;
  logic             in_ready;
  logic             sel_bit;
  logic             op;
  logic [W-1:0]     message0;
  logic [W-1:0]     message1;
  logic [W-1:0]     key;
  logic [W-1:0]     modulus;
  logic             out_valid;
  logic             out_ready;
  logic [W-1:0]     result;
  logic             out_err;
  logic [CNT_W-1:0] done_cnt;

  ot_unpack_stream #(.W(W), .CNT_W(CNT_W)) dut (
    .clk      (clk),
    .rst      (rst),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .sel_bit  (sel_bit),
    .op       (op),
    .message0 (message0),
    .message1 (message1),
    .key      (key),
    .modulus  (modulus),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .result   (result),
    .out_err  (out_err),
    .done_cnt (done_cnt)
  );

  typedef struct {
    logic         sel;
    logic         op;
    logic [W-1:0] m0;
    logic [W-1:0] m1;
    logic [W-1:0] key;
    logic [W-1:0] mod;
    logic [W-1:0] expResult;
    logic         expErr;
  } vecT;

  // edgesAfterAccept counts rising edges after the accept edge up to the
  // first negedge at which out_valid is seen: W+1 normally, 0 for N = 0.
  typedef struct {
    logic [W-1:0] result;
    logic         err;
    int           edgesAfterAccept;
    int           acceptCycle;
  } expT;

  expT expQ[$];
  vecT vecs[NVEC];
  int  checks  = 0;
  int  errors  = 0;
  int  expDone = 0;
  int  cycleCnt = 0;

  // Free-running clock and cycle counter used for latency measurement.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cycleCnt <= cycleCnt + 1;

  // Hard stop in case a sequence wedges despite its own bounded waits.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  function automatic logic [W-1:0] modelCombine(input logic [W-1:0] m,
                                                input logic [W-1:0] k,
                                                input logic [W-1:0] n,
                                                input logic opv);
    longint unsigned a, b, nn;
    if (n == '0) return '0;
    nn = longint'(n);
    a  = longint'(m) % nn;
    b  = longint'(k) % nn;
    if (opv) return W'((a + b) % nn);
    return W'((a + nn - b) % nn);
  endfunction

  task automatic checkValue(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Called at a negedge: waits for in_ready, offers the job for one edge
  // and records what the scoreboard should see later.
  task automatic applyStimulus(input vecT v, input string tag);
    int  waited = 0;
    expT e;
    while (!in_ready && waited < 200) begin
      @(negedge clk);
      waited++;
    end
    if (!in_ready) begin
      checkValue({tag, " in_ready timeout"}, 64'd0, 64'd1);
      return;
    end
    sel_bit  = v.sel;
    op       = v.op;
    message0 = v.m0;
    message1 = v.m1;
    key      = v.key;
    modulus  = v.mod;
    in_valid = 1'b1;
    e.result           = v.expResult;
    e.err              = v.expErr;
    e.edgesAfterAccept = (v.mod == '0) ? 0 : W + 1;
    e.acceptCycle      = cycleCnt + 1;
    expQ.push_back(e);
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  // Called at a negedge: waits for out_valid, compares against the
  // scoreboard head, completes the handshake and checks the aftermath.
  task automatic checkOutput(input string tag);
    int  waited = 0;
    expT e;
    while (!out_valid && waited < 200) begin
      @(negedge clk);
      waited++;
    end
    if (!out_valid) begin
      checkValue({tag, " out_valid timeout"}, 64'd0, 64'd1);
      return;
    end
    if (expQ.size() == 0) begin
      checkValue({tag, " unexpected output"}, 64'd1, 64'd0);
      return;
    end
    e = expQ.pop_front();
    checkValue({tag, " latency"}, 64'(cycleCnt - e.acceptCycle), 64'(e.edgesAfterAccept));
    checkValue({tag, " result"}, 64'(result), 64'(e.result));
    checkValue({tag, " out_err"}, 64'(out_err), 64'(e.err));
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    expDone++;
    checkValue({tag, " done_cnt"}, 64'(done_cnt), 64'(expDone % (1 << CNT_W)));
    checkValue({tag, " out_valid after handshake"}, 64'(out_valid), 64'd0);
    checkValue({tag, " in_ready after handshake"}, 64'(in_ready), 64'd1);
  endtask

  // Main sequence: reset, table, back-pressure hold, reset mid-reduce.
  initial begin
    vecT v;
    expT e;
    int  waited;
    logic [W-1:0] holdRes;

    rst       = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    sel_bit   = 1'b0;
    op        = 1'b0;
    message0  = '0;
    message1  = '0;
    key       = '0;
    modulus   = '0;

    // Fixed vectors with hand-computed answers.
    vecs[0] = '{sel: 1'b1, op: 1'b0, m0: 32'd0,   m1: 32'd100, key: 32'd30, mod: 32'd97,
                expResult: 32'd70, expErr: 1'b0};
    vecs[1] = '{sel: 1'b0, op: 1'b1, m0: 32'd50,  m1: 32'd999, key: 32'd60, mod: 32'd97,
                expResult: 32'd13, expErr: 1'b0};
    vecs[2] = '{sel: 1'b0, op: 1'b0, m0: 32'd50,  m1: 32'd999, key: 32'd60, mod: 32'd97,
                expResult: 32'd87, expErr: 1'b0};
    vecs[3] = '{sel: 1'b0, op: 1'b0, m0: 32'hFFFF_FFFF, m1: 32'd5, key: 32'hFFFF_FFFE,
                mod: 32'hFFFF_FFFB, expResult: 32'd1, expErr: 1'b0};
    vecs[4] = '{sel: 1'b0, op: 1'b1, m0: 32'hFFFF_FFFF, m1: 32'd5, key: 32'hFFFF_FFFE,
                mod: 32'hFFFF_FFFB, expResult: 32'd7, expErr: 1'b0};
    vecs[5] = '{sel: 1'b1, op: 1'b1, m0: 32'd7,   m1: 32'd1234, key: 32'd99, mod: 32'd0,
                expResult: 32'd0, expErr: 1'b1};
    vecs[6] = '{sel: 1'b1, op: 1'b1, m0: 32'd3,   m1: 32'd12345, key: 32'd77, mod: 32'd1,
                expResult: 32'd0, expErr: 1'b0};
    vecs[7] = '{sel: 1'b0, op: 1'b0, m0: 32'd3,   m1: 32'd12345, key: 32'd77, mod: 32'd1,
                expResult: 32'd0, expErr: 1'b0};

    // Random vectors checked against the arithmetic model.
    for (int i = 8; i < NVEC; i++) begin
      v.sel = 1'($urandom_range(0, 1));
      v.op  = 1'($urandom_range(0, 1));
      v.m0  = $urandom;
      v.m1  = $urandom;
      v.key = $urandom;
      v.mod = (i % 2 == 0) ? W'($urandom_range(2, 1000)) : W'($urandom | 32'h1);
      v.expResult = modelCombine(v.sel ? v.m1 : v.m0, v.key, v.mod, v.op);
      v.expErr    = 1'b0;
      vecs[i] = v;
    end

    repeat (2) @(posedge clk);
    @(negedge clk);
    checkValue("reset in_ready", 64'(in_ready), 64'd0);
    checkValue("reset out_valid", 64'(out_valid), 64'd0);
    checkValue("reset result", 64'(result), 64'd0);
    checkValue("reset out_err", 64'(out_err), 64'd0);
    checkValue("reset done_cnt", 64'(done_cnt), 64'd0);
    rst = 1'b0;
    @(negedge clk);

    for (int i = 0; i < NVEC; i++) begin
      applyStimulus(vecs[i], $sformatf("vec%0d", i));
      checkOutput($sformatf("vec%0d", i));
    end

    // Back-pressure: hold out_ready low for 10 cycles while a new job is
    // offered; the result must stay put and nothing may be accepted.
    applyStimulus(vecs[0], "hold");
    waited = 0;
    while (!out_valid && waited < 200) begin
      @(negedge clk);
      waited++;
    end
    checkValue("hold out_valid reached", 64'(out_valid), 64'd1);
    e = expQ.pop_front();
    holdRes  = e.result;
    sel_bit  = 1'b1;
    op       = 1'b1;
    message1 = 32'd200;
    message0 = 32'd1;
    key      = 32'd10;
    modulus  = 32'd97;
    in_valid = 1'b1;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      checkValue($sformatf("hold result c%0d", c), 64'(result), 64'(holdRes));
      checkValue($sformatf("hold in_ready c%0d", c), 64'(in_ready), 64'd0);
      checkValue($sformatf("hold out_valid c%0d", c), 64'(out_valid), 64'd1);
    end
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    expDone++;
    checkValue("hold done_cnt", 64'(done_cnt), 64'(expDone));
    checkValue("hold in_ready back", 64'(in_ready), 64'd1);
    // in_valid is still high, so the pending job is taken on the next edge.
    e.result           = modelCombine(32'd200, 32'd10, 32'd97, 1'b1);
    e.err              = 1'b0;
    e.edgesAfterAccept = W + 1;
    e.acceptCycle      = cycleCnt + 1;
    expQ.push_back(e);
    @(negedge clk);
    in_valid = 1'b0;
    checkOutput("held job");

    // Reset during the tenth REDUCE cycle discards the job entirely.
    applyStimulus(vecs[0], "abort");
    repeat (9) @(negedge clk);
    rst = 1'b1;
    #1;
    checkValue("abort out_valid", 64'(out_valid), 64'd0);
    checkValue("abort done_cnt", 64'(done_cnt), 64'd0);
    checkValue("abort in_ready", 64'(in_ready), 64'd0);
    checkValue("abort result", 64'(result), 64'd0);
    expQ.delete();
    expDone = 0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    checkValue("post-reset out_valid", 64'(out_valid), 64'd0);
    v = vecs[0];
    applyStimulus(v, "post-reset");
    checkOutput("post-reset");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/ot_unpack_stream.md
# ot_unpack_stream

Parametrised receiver/sender modular combine engine for the oblivious-transfer datapath. It accepts a stream of jobs over a valid/ready handshake. For each job it selects one of two messages with the choice bit and reduces both that message and the key modulo N using internal bit-serial reducers. It then returns (m − k) mod N in unpack mode, or (m + k) mod N in pack mode, over a back-pressured output handshake. It replaces single-shot, fixed-32-bit unpack logic and sits between the message receive buffer and the result register file.

## Interface
- W, default 32: operand width (messages, key, modulus, result); W ≥ 2.
- CNT_W, default 16: width of the completed-job counter.
- clk  input  1  clock; all state updates on rising edge.
- rst  input  1  asynchronous, active-high reset.
- in_valid  input  1  job offered.
- in_ready  output  1  block can accept a job.
- sel_bit  input  1  0 selects message0, 1 selects message1.
- op  input  1  0 = unpack (m − k) mod N, 1 = pack (m + k) mod N.
- message0, message1  input  W  candidate messages.
- key  input  W  key/blinding value k.
- modulus  input  W  modulus N.
- out_valid  output  1  result available.
- out_ready  input  1  consumer takes result.
- result  output  W  modular result; 0 when out_valid = 0.
- out_err  output  1  job had N = 0; meaningful only while out_valid = 1.
- done_cnt  output  CNT_W  count of completed output handshakes; wraps modulo 2^CNT_W.

## Operation
- States: IDLE, REDUCE, COMBINE, OUT.
- IDLE:
  - in_ready = 1.
  - On in_valid, capture the selected message, key, N and op; clear both remainders; load bit counter = W−1.
  - If N = 0: result_reg = 0, err = 1, next state OUT.
  - Otherwise err = 0, next state REDUCE.
- REDUCE: each cycle, for each operand X (message, key), in parallel:
  - r ← 2r + X[cnt]; if r ≥ N then r ← r − N.
  - r is W+1 bits wide internally.
  - When cnt = 0 (after W cycles), go to COMBINE; otherwise cnt ← cnt − 1.
  - After REDUCE, both remainders are < N.
- COMBINE, with a = reduced message and k = reduced key:
  - op = 0: result = a ≥ k ? a − k : a − k + N.
  - op = 1: s = a + k (W+1 bits); result = s ≥ N ? s − N : s.
  - Next state OUT.
- OUT:
  - out_valid = 1; result and out_err are held stable.
  - On out_ready: done_cnt += 1, next state IDLE.
  - Otherwise stay in OUT indefinitely.
- in_ready = 0 in REDUCE, COMBINE and OUT; no job is accepted while one is in flight.
- Inputs are sampled only at the accept edge; later input changes have no effect on the job in flight.
- N = 1: normal path, result 0.
- Operands ≥ N are legal and fully reduced.
- Reset (asynchronous, any state, including mid-REDUCE):
  - state = IDLE; in_ready = 0 while rst is high; out_valid = 0, result = 0, out_err = 0, done_cnt = 0.
  - The in-flight job is discarded with no output.

## Timing
- Accept edge e0 (in_valid & in_ready).
- REDUCE occupies edges e1..eW.
- COMBINE is at edge e(W+1); out_valid is high after e(W+1), i.e. latency W+1 cycles from accept to out_valid (33 for W = 32).
- N = 0 fast path: out_valid is high after e0 plus one cycle, i.e. out_valid is 1 in the cycle following the accept.
- Output handshake completes on the edge where out_valid & out_ready; in_ready rises the following cycle.
- Minimum job period: W+3 cycles.
- in_ready and out_valid are pure decodes of the state register (plus rst for in_ready); there is no combinational path from in_valid or out_ready to either.
- done_cnt updates on the handshake edge; 2^CNT_W − 1 increments to 0.

## Test plan
- W=32, sel_bit=1, message1=100, key=30, N=97, op=0 -> out_valid exactly 33 cycles after accept, result=70, out_err=0, done_cnt=1 after handshake.
- sel_bit=0, message0=50, message1=999, key=60, N=97, op=1 -> result=13; repeat with op=0 -> result=87.
- message0=0xFFFFFFFF, key=0xFFFFFFFE, N=0xFFFFFFFB, op=0 -> result=1; op=1 -> result=7 (exercises the W+1-bit remainder and sum).
- N=0, any operands -> out_valid one cycle after accept, result=0, out_err=1; N=1 -> result=0, out_err=0.
- Hold out_ready=0 for 10 cycles in OUT while in_valid=1 with new operands -> result stable, in_ready=0, no second accept; release -> done_cnt increments once, next job accepted only after in_ready returns high.
- Assert rst at REDUCE cycle 10 -> out_valid=0, done_cnt=0 immediately. After deassertion, a new job (message1=100, key=30, N=97) produces 70 with normal latency.
